// File: rtl/inst_bus_if.sv
// Instruction-fetch to Wishbone B4 classic read bridge: turns the core's single-cycle
// ROM read into a multi-cycle bus read, stalling the pipeline until the word returns.
module inst_bus_if #(
  parameter int STALL_BIT = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        err_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_STALL
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic        wb_stb_q, wb_stb_d;
  logic        wb_cyc_q, wb_cyc_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        if_held;
  logic        unused_stall;

  assign if_held      = stall_i[STALL_BIT];
  assign unused_stall = ^stall_i;

  always_comb begin
    state_d  = state_q;
    wb_adr_d = wb_adr_q;
    wb_sel_d = wb_sel_q;
    wb_stb_d = wb_stb_q;
    wb_cyc_d = wb_cyc_q;
    rd_buf_d = rd_buf_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          wb_adr_d = cpu_addr_i;
          wb_sel_d = 4'hF;
          wb_stb_d = 1'b1;
          wb_cyc_d = 1'b1;
          cnt_d    = 8'd0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // Flush beats ack, and ack beats the timeout that would fire in the same cycle.
        if (flush_i) begin
          wb_sel_d = 4'h0;
          wb_stb_d = 1'b0;
          wb_cyc_d = 1'b0;
          state_d  = IDLE;
        end else if (wb_ack_i) begin
          wb_sel_d = 4'h0;
          wb_stb_d = 1'b0;
          wb_cyc_d = 1'b0;
          rd_buf_d = wb_dat_i;
          state_d  = if_held ? WAIT_STALL : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          wb_sel_d = 4'h0;
          wb_stb_d = 1'b0;
          wb_cyc_d = 1'b0;
          rd_buf_d = 32'h0;
          err_d    = 1'b1;
          state_d  = if_held ? WAIT_STALL : IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_STALL: begin
        if (!if_held || flush_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_data_o = 32'h0;
    stallreq_o = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:       stallreq_o = cpu_ce_i && !flush_i;
        BUSY: begin
          if (!flush_i) begin
            if (wb_ack_i) begin
              cpu_data_o = wb_dat_i;
            end else begin
              stallreq_o = 1'b1;
            end
          end
        end
        WAIT_STALL: cpu_data_o = rd_buf_q;
        default: begin
          cpu_data_o = 32'h0;
          stallreq_o = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wb_adr_q <= 32'h0;
      wb_sel_q <= 4'h0;
      wb_stb_q <= 1'b0;
      wb_cyc_q <= 1'b0;
      rd_buf_q <= 32'h0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wb_adr_q <= wb_adr_d;
      wb_sel_q <= wb_sel_d;
      wb_stb_q <= wb_stb_d;
      wb_cyc_q <= wb_cyc_d;
      rd_buf_q <= rd_buf_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign wb_adr_o = wb_adr_q;
  assign wb_sel_o = wb_sel_q;
  assign wb_stb_o = wb_stb_q;
  assign wb_cyc_o = wb_cyc_q;
  assign wb_we_o  = 1'b0;
  assign err_o    = err_q;

endmodule

// File: tb/tb_inst_bus_if.sv
// Self-checking bench for inst_bus_if: directed scenarios plus randomized cycles,
// all checked against a transaction-level model of the fetch bridge.
module tb_inst_bus_if;

  localparam int STALL_BIT = 1;
  localparam int TIMEOUT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  inst_bus_if #(.STALL_BIT(STALL_BIT), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .err_o      (err_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a bus read is either outstanding, or a returned word is being
  // held for a stalled fetch stage, or nothing is happening.
  bit          busOutstanding;
  bit          wordHeld;
  bit          errPulse;
  logic [31:0] latchedAddr;
  logic [31:0] heldWord;
  int          cyclesWaited;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    busOutstanding = 1'b0;
    wordHeld       = 1'b0;
    errPulse       = 1'b0;
    latchedAddr    = 32'h0;
    heldWord       = 32'h0;
    cyclesWaited   = 0;
  endtask

  // Drive one cycle of inputs, check every output against the model, then advance the model.
  task automatic applyStimulus(input logic ce, input logic [31:0] addr, input logic flush,
                               input logic [5:0] stall, input logic ack, input logic [31:0] dat);
    logic [31:0] expData;
    logic        expStall;
    logic        fetchHeld;
    @(negedge clk);
    cpu_ce_i   = ce;
    cpu_addr_i = addr;
    flush_i    = flush;
    stall_i    = stall;
    wb_ack_i   = ack;
    wb_dat_i   = dat;
    #1;
    fetchHeld = stall[STALL_BIT];
    expData   = 32'h0;
    expStall  = 1'b0;
    if (busOutstanding) begin
      if (!flush) begin
        if (ack) expData = dat;
        else     expStall = 1'b1;
      end
    end else if (wordHeld) begin
      expData = heldWord;
    end else begin
      expStall = ce && !flush;
    end
    checkOutput("cpu_data", cpu_data_o, expData);
    checkOutput("stallreq", 32'(stallreq_o), 32'(expStall));
    checkOutput("wb_cyc", 32'(wb_cyc_o), 32'(busOutstanding));
    checkOutput("wb_stb", 32'(wb_stb_o), 32'(busOutstanding));
    checkOutput("wb_sel", 32'(wb_sel_o), busOutstanding ? 32'hF : 32'h0);
    checkOutput("wb_adr", wb_adr_o, latchedAddr);
    checkOutput("wb_we", 32'(wb_we_o), 32'h0);
    checkOutput("err", 32'(err_o), 32'(errPulse));
    @(posedge clk);
    errPulse = 1'b0;
    if (busOutstanding) begin
      if (flush) begin
        busOutstanding = 1'b0;
      end else if (ack) begin
        busOutstanding = 1'b0;
        heldWord       = dat;
        wordHeld       = fetchHeld;
      end else if (cyclesWaited + 1 == TIMEOUT) begin
        busOutstanding = 1'b0;
        heldWord       = 32'h0;
        errPulse       = 1'b1;
        wordHeld       = fetchHeld;
      end else begin
        cyclesWaited++;
      end
    end else if (wordHeld) begin
      if (!fetchHeld || flush) wordHeld = 1'b0;
    end else if (ce && !flush) begin
      busOutstanding = 1'b1;
      latchedAddr    = addr;
      cyclesWaited   = 0;
    end
  endtask

  initial begin
    logic        rCe;
    logic        rFlush;
    logic        rAck;
    logic [5:0]  rStall;
    logic [31:0] rAddr;
    logic [31:0] rDat;

    rst        = 1'b1;
    cpu_ce_i   = 1'b1;
    cpu_addr_i = 32'h8;
    flush_i    = 1'b0;
    stall_i    = 6'h0;
    wb_ack_i   = 1'b0;
    wb_dat_i   = 32'h5555_AAAA;
    resetModel();
    #3;
    checkOutput("rst_cyc", 32'(wb_cyc_o), 32'h0);
    checkOutput("rst_stb", 32'(wb_stb_o), 32'h0);
    checkOutput("rst_sel", 32'(wb_sel_o), 32'h0);
    checkOutput("rst_adr", wb_adr_o, 32'h0);
    checkOutput("rst_err", 32'(err_o), 32'h0);
    checkOutput("rst_stallreq", 32'(stallreq_o), 32'h0);
    checkOutput("rst_data", cpu_data_o, 32'h0);
    @(negedge clk);
    cpu_ce_i = 1'b0;
    rst      = 1'b0;

    $display("[TB] zero-wait slave");
    applyStimulus(1'b1, 32'h0000_0004, 1'b0, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0000_0000, 1'b0, 6'h00, 1'b1, 32'h3401_1100);
    applyStimulus(1'b0, 32'h0000_0000, 1'b0, 6'h00, 1'b1, 32'h7777_7777);

    $display("[TB] three-wait slave, ack coinciding with timeout");
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 6'h00, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h0000_0200 + 32'(i * 4), 1'b0, 6'h00, 1'b0, 32'hABCD_0000);
    applyStimulus(1'b0, 32'h0000_0300, 1'b0, 6'h00, 1'b1, 32'hCAFE_0001);
    applyStimulus(1'b0, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 32'h0);

    $display("[TB] stall after ack");
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, 6'h02, 1'b1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h0000_0014, 1'b0, 6'h02, 1'b1, 32'h0BAD_0BAD);
    applyStimulus(1'b1, 32'h0000_0014, 1'b0, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0000_0014, 1'b0, 6'h00, 1'b1, 32'h1234_5678);
    applyStimulus(1'b0, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 32'h0);

    $display("[TB] flush mid-cycle");
    applyStimulus(1'b1, 32'h0000_0020, 1'b0, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0020, 1'b0, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0020, 1'b1, 6'h02, 1'b1, 32'h1111_1111);
    applyStimulus(1'b0, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 32'h0);

    $display("[TB] timeout");
    applyStimulus(1'b1, 32'h0000_0030, 1'b0, 6'h00, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 32'h0000_0030, 1'b0, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0034, 1'b0, 6'h00, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 32'h0000_0034, 1'b0, 6'h02, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0038, 1'b0, 6'h02, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0000_0038, 1'b0, 6'h00, 1'b0, 32'h0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      rCe    = ($urandom_range(0, 9) < 7);
      rFlush = ($urandom_range(0, 11) == 0);
      rAck   = ($urandom_range(0, 2) == 0);
      rStall = 6'($urandom());
      rAddr  = $urandom() & 32'hFFFF_FFFC;
      rDat   = $urandom();
      applyStimulus(rCe, rAddr, rFlush, rStall, rAck, rDat);
    end

    $display("[TB] async reset mid-BUSY");
    applyStimulus(1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, 6'h00, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_cyc", 32'(wb_cyc_o), 32'h0);
    checkOutput("arst_stb", 32'(wb_stb_o), 32'h0);
    checkOutput("arst_stallreq", 32'(stallreq_o), 32'h0);
    checkOutput("arst_data", cpu_data_o, 32'h0);
    checkOutput("arst_sel", 32'(wb_sel_o), 32'h0);
    checkOutput("arst_adr", wb_adr_o, 32'h0);
    @(negedge clk);
    cpu_ce_i = 1'b0;
    wb_ack_i = 1'b0;
    flush_i  = 1'b0;
    rst      = 1'b0;
    resetModel();
    applyStimulus(1'b0, 32'h0, 1'b0, 6'h00, 1'b1, 32'h9999_9999);
    applyStimulus(1'b1, 32'h0000_0044, 1'b0, 6'h00, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 6'h00, 1'b1, 32'h0F0F_0F0F);
    applyStimulus(1'b0, 32'h0, 1'b0, 6'h00, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
